// File: rtl/tmac_pkg.sv
// Shared Turing-machine definitions: tape geometry, symbol encoding, loader states.
package tmac_pkg;

  // Default tape address width, shared by the tape memory, head pointer and loader.
  localparam int unsigned MEM_SIZE_DEFAULT = 14;

  // Tape symbol encoding.
  localparam logic SYM_ZERO = 1'b0;
  localparam logic SYM_ONE  = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StLoad,
    StDone
  } loader_state_e;

endpackage

// File: rtl/tmac_tape_loader_if.sv
// Symbol stream in, tape write port out. The loader is the slave side of the stream
// and drives the tape write port; the master side is the source plus the tape memory.
interface tmac_tape_loader_if
  import tmac_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEFAULT
);
  logic                in_valid;
  logic                in_sym;
  logic                in_last;
  logic                in_ready;
  logic [MEM_SIZE-1:0] mem_addr;
  logic                mem_din;
  logic                mem_we;

  modport master (
    output in_valid, in_sym, in_last,
    input  in_ready, mem_addr, mem_din, mem_we
  );

  modport slave (
    input  in_valid, in_sym, in_last,
    output in_ready, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/tmac_addr_counter.sv
// Tape address pointer with synchronous clear/increment and an end-of-tape flag.
module tmac_addr_counter
  import tmac_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [MEM_SIZE-1:0] ptr_o,
  output logic                at_max_o
);
  logic [MEM_SIZE-1:0] ptr_q, ptr_d;

  // Clear wins over increment.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + MEM_SIZE'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o    = ptr_q;
  assign at_max_o = &ptr_q;
endmodule

// File: rtl/tmac_tape_loader.sv
// Tape loader: optional zero-fill of the whole tape, then writes a valid/ready symbol
// stream to consecutive addresses from 0 and reports done/count/overflow.
module tmac_tape_loader
  import tmac_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEFAULT,
  parameter bit          CLEAR_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  tmac_tape_loader_if.slave    tape,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [MEM_SIZE:0]    count_o,
  output logic                 err_overflow_o
);
  loader_state_e       state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [MEM_SIZE:0]   count_q, count_d;
  logic                wptr_clr, wptr_inc, wptr_at_max;
  logic [MEM_SIZE-1:0] wptr;

  tmac_addr_counter #(
    .MEM_SIZE (MEM_SIZE)
  ) u_wptr (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wptr_clr),
    .inc_i    (wptr_inc),
    .ptr_o    (wptr),
    .at_max_o (wptr_at_max)
  );

  // Next state, pointer control and the combinational tape/stream outputs.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    err_d         = err_q;
    wptr_clr      = 1'b0;
    wptr_inc      = 1'b0;
    tape.in_ready = 1'b0;
    tape.mem_we   = 1'b0;
    tape.mem_din  = SYM_ZERO;
    tape.mem_addr = wptr;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          wptr_clr = 1'b1;
          count_d  = '0;
          err_d    = 1'b0;
          state_d  = CLEAR_EN ? StClear : StLoad;
        end
      end
      StClear: begin
        tape.mem_we = 1'b1;
        if (wptr_at_max) begin
          wptr_clr = 1'b1;
          state_d  = StLoad;
        end else begin
          wptr_inc = 1'b1;
        end
      end
      StLoad: begin
        tape.in_ready = 1'b1;
        tape.mem_din  = tape.in_sym;
        tape.mem_we   = tape.in_valid;
        if (tape.in_valid) begin
          count_d  = count_q + (MEM_SIZE + 1)'(1);
          // Pointer parks on the last cell rather than wrapping.
          wptr_inc = ~wptr_at_max;
          if (tape.in_last) begin
            state_d = StDone;
          end else if (wptr_at_max) begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StClear) || (state_d == StLoad);
    done_d = (state_d == StDone);
  end

  // State and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign count_o        = count_q;
  assign err_overflow_o = err_q;
endmodule

// File: tb/tb_tmac_tape_loader.sv
// Bench for tmac_tape_loader: two instances (with and without zero-fill) share one
// stimulus stream; a cycle model predicts every output and a tape scoreboard holds contents.
module tb_tmac_tape_loader;
  import tmac_pkg::*;

  localparam int unsigned MS    = 4;
  localparam int          Depth = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start   = 1'b0;
  logic valid   = 1'b0;
  logic sym     = 1'b0;
  logic last    = 1'b0;
  logic prefill = 1'b0;

  logic          busy0, done0, err0, busy1, done1, err1;
  logic [MS:0]   cnt0, cnt1;

  tmac_tape_loader_if #(.MEM_SIZE(MS)) if0 ();
  tmac_tape_loader_if #(.MEM_SIZE(MS)) if1 ();

  assign if0.in_valid = valid;
  assign if0.in_sym   = sym;
  assign if0.in_last  = last;
  assign if1.in_valid = valid;
  assign if1.in_sym   = sym;
  assign if1.in_last  = last;

  tmac_tape_loader #(.MEM_SIZE(MS), .CLEAR_EN(1'b1)) dut0 (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .tape           (if0),
    .busy_o         (busy0),
    .done_o         (done0),
    .count_o        (cnt0),
    .err_overflow_o (err0)
  );

  tmac_tape_loader #(.MEM_SIZE(MS), .CLEAR_EN(1'b0)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .tape           (if1),
    .busy_o         (busy1),
    .done_o         (done1),
    .count_o        (cnt1),
    .err_overflow_o (err1)
  );

  int errors = 0;
  int checks = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Tape memories written by the DUTs.
  logic tape[2][Depth];
  always @(posedge clk) begin
    if (prefill) begin
      for (int k = 0; k < Depth; k++) begin
        tape[0][k] <= 1'b1;
        tape[1][k] <= 1'b1;
      end
    end else begin
      if (if0.mem_we) tape[0][if0.mem_addr] <= if0.mem_din;
      if (if1.mem_we) tape[1][if1.mem_addr] <= if1.mem_din;
    end
  end

  // Behavioural model: clear countdown, loading flag, symbols accepted so far.
  bit   clear_en[2]     = '{1'b1, 1'b0};
  int   m_clear_left[2] = '{0, 0};
  bit   m_loading[2]    = '{1'b0, 1'b0};
  bit   m_done[2]       = '{1'b0, 1'b0};
  bit   m_err[2]        = '{1'b0, 1'b0};
  int   m_count[2]      = '{0, 0};
  logic m_tape[2][Depth];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        m_clear_left[d] <= 0;
        m_loading[d]    <= 1'b0;
        m_done[d]       <= 1'b0;
        m_err[d]        <= 1'b0;
        m_count[d]      <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (prefill) begin
          for (int k = 0; k < Depth; k++) m_tape[d][k] <= 1'b1;
        end
        if (start && !(m_clear_left[d] > 0 || m_loading[d])) begin
          m_count[d] <= 0;
          m_err[d]   <= 1'b0;
          m_done[d]  <= 1'b0;
          if (clear_en[d]) m_clear_left[d] <= Depth;
          else             m_loading[d]    <= 1'b1;
        end else if (m_clear_left[d] > 0) begin
          m_tape[d][Depth - m_clear_left[d]] <= 1'b0;
          m_clear_left[d] <= m_clear_left[d] - 1;
          if (m_clear_left[d] == 1) m_loading[d] <= 1'b1;
        end else if (m_loading[d] && valid) begin
          m_tape[d][m_count[d]] <= sym;
          m_count[d] <= m_count[d] + 1;
          if (last || m_count[d] + 1 == Depth) begin
            m_loading[d] <= 1'b0;
            m_done[d]    <= 1'b1;
            m_err[d]     <= !last;
          end
        end
      end
    end
  end

  task automatic chk_dut(input int d, input logic rdy, input logic we, input int addr,
                         input logic din, input logic bsy, input logic dn, input int cnt,
                         input logic er);
    bit e_clr;
    bit e_we;
    e_clr = m_clear_left[d] > 0;
    e_we  = e_clr || (m_loading[d] && valid);
    cmp($sformatf("in_ready[%0d]", d), int'(rdy), int'(m_loading[d]));
    cmp($sformatf("mem_we[%0d]", d), int'(we), int'(e_we));
    if (e_we) begin
      cmp($sformatf("mem_addr[%0d]", d), addr, e_clr ? Depth - m_clear_left[d] : m_count[d]);
      cmp($sformatf("mem_din[%0d]", d), int'(din), e_clr ? 0 : int'(sym));
    end
    cmp($sformatf("busy[%0d]", d), int'(bsy), int'(e_clr || m_loading[d]));
    cmp($sformatf("done[%0d]", d), int'(dn), int'(m_done[d]));
    cmp($sformatf("count[%0d]", d), cnt, m_count[d]);
    cmp($sformatf("err_overflow[%0d]", d), int'(er), int'(m_err[d]));
  endtask

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk_dut(0, if0.in_ready, if0.mem_we, int'(if0.mem_addr), if0.mem_din, busy0, done0,
            int'(cnt0), err0);
    chk_dut(1, if1.in_ready, if1.mem_we, int'(if1.mem_addr), if1.mem_din, busy1, done1,
            int'(cnt1), err1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!if0.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) cmp("wait_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic l);
    int n = 0;
    valid = 1'b1;
    sym   = s;
    last  = l;
    @(negedge clk);
    while (!if0.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) cmp("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic gap(input int n);
    valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_tapes();
    for (int k = 0; k < Depth; k++) begin
      cmp($sformatf("tape0[%0d]", k), int'(tape[0][k]), int'(m_tape[0][k]));
      cmp($sformatf("tape1[%0d]", k), int'(tape[1][k]), int'(m_tape[1][k]));
    end
  endtask

  task automatic check_tape_lit(input int d, input logic [15:0] exp);
    for (int k = 0; k < Depth; k++) begin
      cmp($sformatf("tape%0d_lit[%0d]", d, k), int'(tape[d][k]), int'(exp[k]));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int nclr;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_in_ready", int'(if0.in_ready), 0);
    cmp("rst_mem_we", int'(if0.mem_we), 0);
    cmp("rst_busy", int'(busy0), 0);
    cmp("rst_done", int'(done1), 0);
    cmp("rst_count", int'(cnt0), 0);
    rst = 1'b0;
    tick();

    // Basic load with pre-filled ones.
    prefill = 1'b1;
    tick();
    prefill = 1'b0;
    do_start();
    nclr = 0;
    @(negedge clk);
    while (if0.mem_we && !if0.in_ready && !if0.mem_din && nclr < 40) begin
      nclr++;
      @(negedge clk);
    end
    cmp("clear_cycles", nclr, 16);
    @(posedge clk);
    #1;
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    tick();
    cmp("t1_count", int'(cnt0), 4);
    cmp("t1_done", int'(done0), 1);
    cmp("t1_err", int'(err0), 0);
    cmp("t1_count1", int'(cnt1), 4);
    check_tape_lit(0, 16'h000D);
    check_tape_lit(1, 16'hFFFD);
    check_tapes();

    // Backpressure and gaps: valid 1,0,0,1,0,1 with symbols 1,1,0.
    do_start();
    wait_ready();
    send(1'b1, 1'b0);
    gap(2);
    send(1'b1, 1'b0);
    gap(1);
    send(1'b0, 1'b1);
    tick();
    cmp("t2_count1", int'(cnt1), 3);
    cmp("t2_done1", int'(done1), 1);
    check_tape_lit(1, 16'hFFFB);
    check_tapes();

    // Overflow: 17 symbols, no last.
    do_start();
    wait_ready();
    for (int i = 0; i < 16; i++) send(logic'(i % 2), 1'b0);
    valid = 1'b1;
    sym   = 1'b1;
    last  = 1'b0;
    @(negedge clk);
    cmp("t3_ready_after_full", int'(if0.in_ready), 0);
    repeat (3) tick();
    valid = 1'b0;
    cmp("t3_err", int'(err0), 1);
    cmp("t3_count", int'(cnt0), 16);
    cmp("t3_done", int'(done0), 1);
    cmp("t3_err1", int'(err1), 1);
    check_tape_lit(0, 16'hAAAA);
    check_tapes();

    // Exact fill: last on the 16th symbol.
    do_start();
    wait_ready();
    for (int i = 0; i < 16; i++) send(logic'(i < 8), logic'(i == 15));
    tick();
    cmp("t4_err", int'(err0), 0);
    cmp("t4_count", int'(cnt0), 16);
    cmp("t4_done", int'(done0), 1);
    check_tape_lit(0, 16'h00FF);
    check_tapes();

    // Start during CLEAR is ignored; restart from DONE.
    do_start();
    repeat (5) tick();
    do_start();
    wait_ready();
    send(1'b0, 1'b0);
    send(1'b1, 1'b1);
    tick();
    cmp("t5_count_a", int'(cnt0), 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    cmp("t5_done_fell", int'(done0), 0);
    cmp("t5_count_clr", int'(cnt0), 0);
    wait_ready();
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    tick();
    cmp("t5_count_b", int'(cnt0), 3);
    check_tape_lit(0, 16'h0003);
    check_tapes();

    // Async reset mid-load after two accepted symbols.
    do_start();
    wait_ready();
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    cmp("t6_in_ready", int'(if0.in_ready), 0);
    cmp("t6_mem_we", int'(if0.mem_we), 0);
    cmp("t6_busy", int'(busy0), 0);
    cmp("t6_done", int'(done0), 0);
    cmp("t6_count", int'(cnt0), 0);
    cmp("t6_count1", int'(cnt1), 0);
    valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_start();
    wait_ready();
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    tick();
    cmp("t6_fresh_count", int'(cnt0), 2);
    cmp("t6_fresh_err", int'(err0), 0);
    cmp("t6_fresh_done", int'(done0), 1);
    check_tape_lit(0, 16'h0003);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tmac_tape_loader.md
Name: tmac_tape_loader

Overview:
- Fills the Turing machine's tape (input) memory before a run; it is the writer side of the tape the machine reads.
- On `start`, it optionally zero-fills the whole tape.
- It then accepts a stream of 1-bit symbols over a valid/ready handshake and writes them to consecutive tape addresses starting at 0, the head origin.
- It signals `done` so the control logic can release the machine from reset.

Parameters:
- MEM_SIZE, 14, tape address width; tape depth is 2**MEM_SIZE cells.
- CLEAR_EN, 1, 1 = zero-fill the whole tape before loading; 0 = skip the fill.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- in_valid  input  1  the source presents a symbol.
- in_sym  input  1  symbol value (0 or 1).
- in_last  input  1  marks the final symbol; qualified by in_valid.
- in_ready  output  1  the loader accepts a symbol this cycle.
- mem_addr  output  MEM_SIZE  tape write address.
- mem_din  output  1  tape write data.
- mem_we  output  1  tape write enable; the tape memory writes on the same rising edge.
- busy  output  1  high in CLEAR and LOAD.
- done  output  1  high in DONE.
- count  output  MEM_SIZE+1  number of symbols loaded in the last or current load.
- err_overflow  output  1  the tape filled before in_last was seen.

Behaviour:
- Reset (async, any state):
  - state goes to IDLE; wptr, count, err_overflow go to 0.
  - All outputs are 0, including in_ready and mem_we.
  - Tape contents after a mid-load reset are undefined. The bench must not check them.
- States: IDLE, CLEAR, LOAD, DONE. Encoding lives in the package.
- IDLE:
  - in_ready=0, mem_we=0.
  - On start: wptr<=0, count<=0, err_overflow<=0. Go to CLEAR if CLEAR_EN, else LOAD.
- CLEAR:
  - mem_we=1, mem_addr=wptr, mem_din=0, in_ready=0.
  - wptr increments every cycle.
  - When wptr == 2**MEM_SIZE-1: wptr<=0 and go to LOAD. The fill takes exactly 2**MEM_SIZE cycles.
  - start is ignored.
- LOAD:
  - in_ready=1; mem_addr=wptr; mem_din=in_sym; mem_we=in_valid (combinational).
  - A symbol is accepted when in_valid & in_ready. The write happens on that same edge (zero latency); then wptr++ and count++.
  - If the accepted symbol has in_last=1: go to DONE.
  - If the accepted symbol is at wptr == 2**MEM_SIZE-1 with in_last=0: err_overflow<=1 and go to DONE. wptr never wraps. Further symbols are not accepted (in_ready=0 from the next cycle).
  - If in_last=1 at the last address: go to DONE, err_overflow stays 0.
  - An idle source (in_valid=0) may stall indefinitely with no timeout.
  - start is ignored.
- DONE:
  - done=1 (level); in_ready=0, mem_we=0.
  - count and err_overflow hold.
  - start restarts exactly as from IDLE: done drops the next cycle.
- Width and arithmetic:
  - wptr is MEM_SIZE bits.
  - count is MEM_SIZE+1 bits so that a full tape reports 2**MEM_SIZE.
  - count saturates by construction; it never exceeds depth.
- Simultaneous events:
  - start in CLEAR/LOAD: ignored.
  - in_valid in IDLE/CLEAR/DONE: ignored; nothing is written and count does not change.
  - in_valid with in_last on the first LOAD cycle: count=1, then DONE.
- Outputs other than mem_* and in_ready are registered.

Decomposition:
- Package tmac_pkg holds:
  - the loader state enum (IDLE, CLEAR, LOAD, DONE);
  - the default MEM_SIZE constant of 14, shared with the tape memory and head pointer;
  - the symbol encoding constants SYM_ZERO and SYM_ONE.
- One sub-module, tmac_addr_counter:
  - MEM_SIZE-bit pointer with synchronous clear and increment;
  - async reset on rst;
  - an `at_max` flag output (pointer == 2**MEM_SIZE-1).
  - Used for wptr in both CLEAR and LOAD.

Test Plan (MEM_SIZE=4, depth 16):
- Basic load, CLEAR_EN=1:
  - Stimulus: tape pre-filled with all ones; start; stream 1,0,1,1 with in_last on the 4th symbol.
  - Response: 16 CLEAR cycles with mem_we=1 and mem_din=0. Then tape[0..3]=1,0,1,1 and tape[4..15]=0; count=4, done=1, err_overflow=0.
- Backpressure and gaps, CLEAR_EN=0:
  - Stimulus: in_valid toggled 1,0,0,1,0,1 with symbols 1,1,0, last on the third.
  - Response: exactly 3 writes at addresses 0,1,2; mem_we=0 in the gap cycles; count=3.
- Overflow:
  - Stimulus: stream 17 symbols with no in_last.
  - Response: 16 writes at addresses 0..15; err_overflow=1, count=16, done=1. in_ready=0 after the 16th symbol and the 17th is never accepted.
- Exact fill:
  - Stimulus: 16 symbols with in_last on the 16th.
  - Response: err_overflow=0, count=16, done=1.
- Restart and ignored start:
  - Stimulus: start pulsed during CLEAR, then a second start in DONE.
  - Response: CLEAR still lasts exactly 16 cycles. The second start clears count and err_overflow, done falls the next cycle, and the load repeats correctly.
- Async reset mid-LOAD:
  - Stimulus: assert rst between clock edges after 2 accepted symbols.
  - Response: in_ready, mem_we, busy, done and count are 0 immediately, without waiting for a clock edge. The next start behaves as a fresh load.
